// File: rtl/rng_deal_ctrl.sv
// Card-deal controller: round-robin arbitration over NUM_CH request channels,
// RNG fetch with range rejection, and a dealt-card bitmap with linear probing.
module rng_deal_ctrl #(
  parameter  int unsigned NUM_CH    = 4,
  parameter  int unsigned DECK_SIZE = 52,
  parameter  int unsigned RND_W     = 8,
  localparam int unsigned CARD_W    = $clog2(DECK_SIZE),
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] req_card_i,
  input  logic              shuffle_i,
  input  logic              rnd_valid_i,
  input  logic [RND_W-1:0]  rnd_data_i,
  output logic              rnd_req_o,
  output logic              card_valid_o,
  output logic [CARD_W-1:0] card_o,
  output logic [CH_W-1:0]   card_ch_o,
  input  logic              card_ack_i,
  output logic              deck_empty_o,
  output logic              busy_o,
  output logic [1:0]        state_o
);

  localparam int unsigned CNT_W = $clog2(DECK_SIZE + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    CHECK = 2'd2,
    SEND  = 2'd3
  } state_t;

  state_t                state;
  logic [NUM_CH-1:0]     pend;
  logic [DECK_SIZE-1:0]  dealt;
  logic [CNT_W-1:0]      dealt_cnt;
  logic [CH_W-1:0]       rr_ptr;
  logic [CH_W-1:0]       grant;
  logic [CARD_W-1:0]     idx;
  logic                  shuf_pend;

  logic [2*NUM_CH-1:0]   pend_dbl_c;
  logic [NUM_CH-1:0]     pend_rot_c;
  logic [CH_W:0]         gnt_sum_c;
  logic [CH_W-1:0]       gnt_c;
  logic [NUM_CH-1:0]     clr_c;
  logic                  in_range_c;

  // Rotate pending flags so bit 0 is the round-robin pointer; lowest set bit wins.
  always_comb begin
    pend_dbl_c = {pend, pend} >> rr_ptr;
    pend_rot_c = pend_dbl_c[NUM_CH-1:0];
    gnt_sum_c  = '0;
    gnt_c      = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (pend_rot_c[i]) begin
        gnt_sum_c = {1'b0, rr_ptr} + (CH_W+1)'(i);
        if (gnt_sum_c >= (CH_W+1)'(NUM_CH)) gnt_sum_c = gnt_sum_c - (CH_W+1)'(NUM_CH);
        gnt_c = CH_W'(gnt_sum_c);
      end
    end
  end

  always_comb begin
    clr_c      = (state == SEND && card_ack_i) ? (NUM_CH'(1) << grant) : '0;
    in_range_c = {1'b0, rnd_data_i} < (RND_W+1)'(DECK_SIZE);
  end

  assign state_o = state;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      pend         <= '0;
      dealt        <= '0;
      dealt_cnt    <= '0;
      rr_ptr       <= '0;
      grant        <= '0;
      idx          <= '0;
      shuf_pend    <= 1'b0;
      rnd_req_o    <= 1'b0;
      card_valid_o <= 1'b0;
      card_o       <= '0;
      card_ch_o    <= '0;
      deck_empty_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      // A new request wins over the clear of the channel being acknowledged.
      pend <= (pend & ~clr_c) | req_card_i;
      if (shuffle_i && state != IDLE) shuf_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (shuf_pend || shuffle_i) begin
            dealt        <= '0;
            dealt_cnt    <= '0;
            deck_empty_o <= 1'b0;
            shuf_pend    <= 1'b0;
          end else if (|pend && !deck_empty_o) begin
            grant     <= gnt_c;
            state     <= FETCH;
            rnd_req_o <= 1'b1;
            busy_o    <= 1'b1;
          end
        end
        FETCH: begin
          if (rnd_valid_i && in_range_c) begin
            idx       <= rnd_data_i[CARD_W-1:0];
            rnd_req_o <= 1'b0;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (!dealt[idx]) begin
            dealt[idx]   <= 1'b1;
            dealt_cnt    <= dealt_cnt + CNT_W'(1);
            deck_empty_o <= (dealt_cnt + CNT_W'(1)) == CNT_W'(DECK_SIZE);
            card_valid_o <= 1'b1;
            card_o       <= idx;
            card_ch_o    <= grant;
            state        <= SEND;
          end else begin
            // Probe terminates: a free card exists whenever we left IDLE.
            idx <= (idx == CARD_W'(DECK_SIZE - 1)) ? '0 : idx + CARD_W'(1);
          end
        end
        SEND: begin
          if (card_ack_i) begin
            card_valid_o <= 1'b0;
            rr_ptr       <= (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + CH_W'(1);
            busy_o       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rng_deal_ctrl.sv
// Directed bench for rng_deal_ctrl: table of single deals plus hand sequences
// for rejection, round robin, backpressure, exhaustion, shuffle and reset.
module tb_rng_deal_ctrl;

  localparam int unsigned NUM_CH    = 4;
  localparam int unsigned DECK_SIZE = 52;
  localparam int unsigned RND_W     = 8;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [3:0]        req_card_i;
  logic              shuffle_i;
  logic              rnd_valid_i;
  logic [7:0]        rnd_data_i;
  logic              rnd_req_o;
  logic              card_valid_o;
  logic [5:0]        card_o;
  logic [1:0]        card_ch_o;
  logic              card_ack_i;
  logic              deck_empty_o;
  logic              busy_o;
  logic [1:0]        state_o;

  int checks = 0;
  int errors = 0;

  rng_deal_ctrl #(.NUM_CH(NUM_CH), .DECK_SIZE(DECK_SIZE), .RND_W(RND_W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_card_i   (req_card_i),
    .shuffle_i    (shuffle_i),
    .rnd_valid_i  (rnd_valid_i),
    .rnd_data_i   (rnd_data_i),
    .rnd_req_o    (rnd_req_o),
    .card_valid_o (card_valid_o),
    .card_o       (card_o),
    .card_ch_o    (card_ch_o),
    .card_ack_i   (card_ack_i),
    .deck_empty_o (deck_empty_o),
    .busy_o       (busy_o),
    .state_o      (state_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] mask;
    logic [7:0] data;
    int         card;
    int         ch;
    int         lat;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    req_card_i  = '0;
    shuffle_i   = 1'b0;
    rnd_valid_i = 1'b0;
    rnd_data_i  = '0;
    card_ack_i  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
    tick();
  endtask

  task automatic wait_card(output int n);
    n = 0;
    while (!card_valid_o && n < 500) begin
      tick();
      n++;
    end
    chk("card_wait", 32'(card_valid_o), 1);
  endtask

  task automatic ack_card();
    card_ack_i = 1'b1;
    tick();
    card_ack_i = 1'b0;
    chk("ack_valid_drop", 32'(card_valid_o), 0);
    chk("ack_state_idle", 32'(state_o), 0);
    chk("ack_busy", 32'(busy_o), 0);
  endtask

  task automatic do_deal(input logic [3:0] mask, input logic [7:0] data,
                         input int exp_card, input int exp_ch, input int exp_lat);
    int n;
    req_card_i  = mask;
    rnd_valid_i = 1'b1;
    rnd_data_i  = data;
    tick();
    req_card_i = '0;
    n = 1;
    while (!card_valid_o && n < 200) begin
      tick();
      n++;
    end
    chk("deal_latency", 32'(n), 32'(exp_lat));
    chk("deal_card", 32'(card_o), 32'(exp_card));
    chk("deal_ch", 32'(card_ch_o), 32'(exp_ch));
    chk("deal_state_send", 32'(state_o), 3);
    chk("deal_busy", 32'(busy_o), 1);
    ack_card();
  endtask

  initial begin
    int n;
    int exp_rr_ch[5];
    bit [DECK_SIZE-1:0] seen;
    bit saw_req;

    vecs[0] = '{4'b0001, 8'd5,  5,  0, 4};
    vecs[1] = '{4'b0010, 8'd5,  6,  1, 5};
    vecs[2] = '{4'b1000, 8'd51, 51, 3, 4};
    vecs[3] = '{4'b0100, 8'd51, 0,  2, 5};
    vecs[4] = '{4'b0001, 8'd50, 50, 0, 4};
    vecs[5] = '{4'b0010, 8'd50, 1,  1, 7};
    exp_rr_ch = '{0, 1, 2, 3, 0};

    // Reset with random inputs
    rst_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_card_i  = 4'($urandom);
      shuffle_i   = 1'($urandom);
      rnd_valid_i = 1'($urandom);
      rnd_data_i  = 8'($urandom);
      card_ack_i  = 1'($urandom);
      tick();
    end
    chk("rst_rnd_req", 32'(rnd_req_o), 0);
    chk("rst_card_valid", 32'(card_valid_o), 0);
    chk("rst_card", 32'(card_o), 0);
    chk("rst_card_ch", 32'(card_ch_o), 0);
    chk("rst_deck_empty", 32'(deck_empty_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_state", 32'(state_o), 0);
    idle_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    tick();
    chk("post_rst_state", 32'(state_o), 0);
    chk("post_rst_busy", 32'(busy_o), 0);
    chk("post_rst_rnd_req", 32'(rnd_req_o), 0);
    chk("post_rst_card_valid", 32'(card_valid_o), 0);

    // Table of single deals including collision probes and wrap from 51 to 0
    for (int v = 0; v < 6; v++)
      do_deal(vecs[v].mask, vecs[v].data, vecs[v].card, vecs[v].ch, vecs[v].lat);

    // Out-of-range value rejected, fetch continues
    req_card_i  = 4'b0100;
    rnd_valid_i = 1'b1;
    rnd_data_i  = 8'd60;
    tick();
    req_card_i = '0;
    chk("rej_pend_idle", 32'(state_o), 0);
    tick();
    chk("rej_fetch", 32'(state_o), 1);
    chk("rej_rnd_req1", 32'(rnd_req_o), 1);
    tick();
    chk("rej_stay_fetch", 32'(state_o), 1);
    chk("rej_rnd_req2", 32'(rnd_req_o), 1);
    rnd_data_i = 8'd7;
    tick();
    chk("rej_check", 32'(state_o), 2);
    chk("rej_rnd_req_drop", 32'(rnd_req_o), 0);
    tick();
    chk("rej_valid", 32'(card_valid_o), 1);
    chk("rej_card", 32'(card_o), 7);
    chk("rej_ch", 32'(card_ch_o), 2);
    ack_card();

    // Round robin with backpressure and re-request in the ack cycle
    do_reset();
    req_card_i  = 4'b1111;
    rnd_valid_i = 1'b1;
    rnd_data_i  = 8'd10;
    tick();
    req_card_i = '0;
    for (int k = 0; k < 5; k++) begin
      wait_card(n);
      chk("rr_card", 32'(card_o), 32'(10 + k));
      chk("rr_ch", 32'(card_ch_o), 32'(exp_rr_ch[k]));
      if (k == 0) begin
        for (int c = 0; c < 10; c++) begin
          tick();
          chk("bp_valid", 32'(card_valid_o), 1);
          chk("bp_card", 32'(card_o), 10);
          chk("bp_ch", 32'(card_ch_o), 0);
          chk("bp_state", 32'(state_o), 3);
        end
      end
      card_ack_i = 1'b1;
      req_card_i = (k == 0) ? 4'b0001 : 4'b0000;
      tick();
      card_ack_i = 1'b0;
      req_card_i = '0;
      chk("rr_ack_idle", 32'(state_o), 0);
    end

    // Exhaust the deck with random values
    do_reset();
    seen = '0;
    for (int i = 0; i < int'(DECK_SIZE); i++) begin
      req_card_i  = 4'(1 << (i % 4));
      rnd_valid_i = 1'b1;
      rnd_data_i  = 8'($urandom);
      tick();
      req_card_i = '0;
      n = 1;
      while (!card_valid_o && n < 3000) begin
        rnd_data_i = 8'($urandom);
        tick();
        n++;
      end
      chk("ex_valid", 32'(card_valid_o), 1);
      chk("ex_range", 32'(card_o < 6'(DECK_SIZE)), 1);
      if (card_o < 6'(DECK_SIZE)) begin
        chk("ex_unique", 32'(seen[card_o]), 0);
        seen[card_o] = 1'b1;
      end
      chk("ex_ch", 32'(card_ch_o), 32'(i % 4));
      chk("ex_deck_empty", 32'(deck_empty_o), 32'(i == int'(DECK_SIZE) - 1));
      ack_card();
    end

    // Request on an empty deck stays pending
    req_card_i  = 4'b0010;
    rnd_valid_i = 1'b1;
    rnd_data_i  = 8'd20;
    tick();
    req_card_i = '0;
    saw_req = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rnd_req_o) saw_req = 1'b1;
    end
    chk("empty_no_rnd_req", 32'(saw_req), 0);
    chk("empty_state", 32'(state_o), 0);
    chk("empty_flag", 32'(deck_empty_o), 1);

    // Shuffle refills the deck and the pending request is served
    shuffle_i = 1'b1;
    tick();
    shuffle_i = 1'b0;
    chk("shuf_deck_empty", 32'(deck_empty_o), 0);
    chk("shuf_stay_idle", 32'(state_o), 0);
    tick();
    chk("shuf_fetch", 32'(state_o), 1);
    tick();
    tick();
    chk("shuf_valid", 32'(card_valid_o), 1);
    chk("shuf_card", 32'(card_o), 20);
    chk("shuf_ch", 32'(card_ch_o), 1);
    ack_card();

    // Shuffle during FETCH is deferred until IDLE
    rnd_valid_i = 1'b0;
    req_card_i  = 4'b0100;
    tick();
    req_card_i = '0;
    tick();
    chk("dshuf_fetch", 32'(state_o), 1);
    shuffle_i = 1'b1;
    tick();
    shuffle_i = 1'b0;
    chk("dshuf_still_fetch", 32'(state_o), 1);
    rnd_valid_i = 1'b1;
    rnd_data_i  = 8'd20;
    wait_card(n);
    chk("dshuf_card_probe", 32'(card_o), 21);
    chk("dshuf_ch", 32'(card_ch_o), 2);
    ack_card();
    do_deal(4'b1000, 8'd20, 20, 3, 4);

    // Reset while a card is being offered
    req_card_i  = 4'b0001;
    rnd_valid_i = 1'b1;
    rnd_data_i  = 8'd33;
    tick();
    req_card_i = '0;
    wait_card(n);
    chk("mid_rst_card", 32'(card_o), 33);
    rst_i = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(card_valid_o), 0);
    chk("mid_rst_state", 32'(state_o), 0);
    chk("mid_rst_busy", 32'(busy_o), 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();
    do_deal(4'b0001, 8'd33, 33, 0, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rng_deal_ctrl.md
Name: rng_deal_ctrl

Overview:
- Parametrised successor to the single-channel card-request control path.
- Serves NUM_CH independent card-request channels with round-robin arbitration.
- Fetches random values from the RNG datapath over a req/valid handshake and rejects out-of-range values.
- Tracks dealt cards in a DECK_SIZE bitmap so no card is dealt twice before a shuffle; returns each card with the channel id over a valid/ack handshake.

Parameters:
- NUM_CH, 4, number of requesting channels (>=1).
- DECK_SIZE, 52, number of distinct cards (>=2).
- RND_W, 8, width of the random value from the datapath; 2^RND_W >= DECK_SIZE required.
- Derived localparams: CARD_W = $clog2(DECK_SIZE); CH_W = max(1, $clog2(NUM_CH)).

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- req_card_i  in  NUM_CH  per-channel card request; sampled each cycle, a high cycle sets that channel's pending flag.
- shuffle_i  in  1  single-cycle pulse: return all cards to the deck.
- rnd_valid_i  in  1  datapath has a random value on rnd_data_i.
- rnd_data_i  in  RND_W  random value.
- rnd_req_o  out  1  controller requests a random value.
- card_valid_o  out  1  card_o and card_ch_o are valid.
- card_o  out  CARD_W  dealt card index, 0..DECK_SIZE-1.
- card_ch_o  out  CH_W  channel the card is dealt to.
- card_ack_i  in  1  consumer accepts the card.
- deck_empty_o  out  1  all DECK_SIZE cards are dealt.
- busy_o  out  1  FSM is not in IDLE.
- state_o  out  2  current FSM state, encoded as listed below.

Behaviour:
- Reset (rst_i low, asynchronous):
  - All outputs are 0; state is IDLE.
  - The pending flags, dealt bitmap, dealt counter, round-robin pointer and shuffle latch are cleared.
- Pending flags: pend_n = (pend & ~clr) | req_card_i. A set wins over a clear in the same cycle. Each channel holds at most one outstanding request; further requests merge into it.
- FSM states: IDLE=0, FETCH=1, CHECK=2, SEND=3.
- IDLE:
  - If the shuffle latch or shuffle_i is set, clear the bitmap and counter and stay in IDLE for that cycle.
  - Otherwise, if any pending flag is set and the deck is not empty, grant the first pending channel at or after the round-robin pointer (wrapping) and go to FETCH.
  - If a flag is pending but the deck is empty, stay in IDLE. Requests stay pending.
- FETCH:
  - rnd_req_o=1. A transfer occurs when rnd_req_o and rnd_valid_i are both high.
  - If rnd_data_i >= DECK_SIZE, discard it and stay in FETCH. rnd_req_o stays high.
  - Otherwise capture idx = rnd_data_i[CARD_W-1:0] and go to CHECK.
- CHECK:
  - If bitmap[idx]==0, set bitmap[idx], increment the counter, and go to SEND.
  - Otherwise idx = (idx==DECK_SIZE-1) ? 0 : idx+1 and stay in CHECK. This linear probe terminates because the deck is not empty.
- SEND:
  - card_valid_o=1, card_o=idx, card_ch_o=grant. All three are registered and held stable until acknowledged.
  - On card_ack_i: clear pend[grant], set rr_ptr = (grant+1) mod NUM_CH, go to IDLE.
  - card_valid_o drops in the next cycle.
- Minimum latency: req_card_i high in cycle t gives pend=1 in t+1, FETCH/rnd_req_o in t+2, CHECK in t+3 (if rnd_valid_i was high in t+2 with an in-range value), and card_valid_o in t+4 for an undealt card. Each probe step adds 1 cycle.
- Outputs:
  - deck_empty_o = (counter == DECK_SIZE), registered.
  - busy_o = (state != IDLE).
  - state_o = state register.
- shuffle_i outside IDLE: latched and applied on the next IDLE cycle. The card in flight stays dealt until that shuffle.
- The counter never exceeds DECK_SIZE. The round-robin pointer wraps at NUM_CH; for non-power-of-2 NUM_CH, values >= NUM_CH do not occur.
- Reset asserted mid-operation (any state) aborts immediately. The in-flight card is not delivered and the deck is full after reset.

Test Plan:
- Reset: hold rst_i low with random inputs -> all outputs 0, state_o=0; after release with no requests, outputs remain 0.
- Single deal: fresh deck, pulse req_card_i=4'b0001 at t, rnd_valid_i=1, rnd_data_i=5 -> card_valid_o at t+4, card_o=5, card_ch_o=0; ack -> IDLE next cycle, busy_o=0.
- Rejection: req on ch2, rnd_data_i=60 for one transfer, then 7 -> two rnd_req_o transfers, card_o=7, card_ch_o=2. Collision: deal card 51, then request with rnd_data_i=51 -> probe wraps, card_o=0, one extra CHECK cycle.
- Round robin and backpressure: req_card_i=4'b1111 in one cycle -> cards dealt to ch0,1,2,3 in order. Hold card_ack_i low for 10 cycles in SEND -> outputs stable. A new req on the granted channel in the ack cycle -> that channel is served again after the others.
- Exhaustion and shuffle:
  - 52 deals -> all card_o values unique; deck_empty_o=1 after the 52nd CHECK.
  - A 53rd request -> pending, no rnd_req_o.
  - shuffle_i pulse -> deck_empty_o=0 and the pending request is served.
  - shuffle_i during FETCH -> deferred until IDLE.
- Reset mid-SEND: assert rst_i while card_valid_o=1 -> card_valid_o=0 immediately; after release, a new deal may return the same card index.
